bht_predictor: RTL
==================

BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of 2-bit counters (power of two, 4..256).
REQ-002 SHALL have parameter IDX_W, default 4, index width, equal to log2(ENTRIES).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port pc_i, input, 32, IF-stage PC used for lookup.
REQ-006 SHALL have port predict_o, output, 1, prediction for pc_i; 1 = taken.
REQ-007 SHALL have port update_i, input, 1, EX-stage branch resolved this cycle.
REQ-008 SHALL have port update_pc_i, input, 32, PC of the resolving branch.
REQ-009 SHALL have port taken_i, input, 1, actual outcome of the resolving branch.
REQ-010 SHALL have port predicted_i, input, 1, prediction carried down the pipe with that branch.
REQ-011 SHALL have port clear_i, input, 1, synchronous table clear.
REQ-012 SHALL have port mispredict_o, output, 1, resolving branch was mispredicted; drives IF/ID flush.
REQ-013 SHALL have port branch_cnt_o, output, 16, resolved-branch count.
REQ-014 SHALL have port miss_cnt_o, output, 16, misprediction count.

Function
REQ-015 SHALL hold ENTRIES 2-bit saturating counters; encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 SHALL index lookup by pc_i[IDX_W+1:2] and update by update_pc_i[IDX_W+1:2]; upper PC bits ignored (aliasing allowed).
REQ-017 SHALL drive predict_o combinationally as bit 1 of the indexed counter, with zero cycles latency.
REQ-018 SHALL, on a clock edge with update_i=1 and taken_i=1, increment the indexed counter, saturating at 11.
REQ-019 SHALL, on a clock edge with update_i=1 and taken_i=0, decrement the indexed counter, saturating at 00.
REQ-020 SHALL leave all counters unchanged when update_i=0.
REQ-021 SHALL, when lookup and update hit the same index in one cycle, drive predict_o from the pre-update value, with no bypass; the new value becomes visible the next cycle.
REQ-022 SHALL drive mispredict_o = update_i AND (taken_i XOR predicted_i), combinationally.
REQ-023 SHALL, on a clock edge with clear_i=1, set every counter to 11; clear_i takes priority over a simultaneous update_i.
REQ-024 SHALL ignore pc_i and update_pc_i bits [1:0].

Reset
REQ-025 SHALL, while rst_i=0, immediately set every counter to 11, and set branch_cnt_o and miss_cnt_o to 0, independent of clk_i.
REQ-026 SHALL drive predict_o=1 after reset for any pc_i, and mispredict_o as per REQ-022.
REQ-027 SHALL let reset asserted mid-update win: no partial counter write persists.
REQ-028 SHALL take its first update on the first rising edge after rst_i returns high.

Configuration
REQ-029 SHALL provide macro BHT_STATS_EN to compile the statistics counters in or out.
REQ-030 SHALL, with BHT_STATS_EN defined, increment branch_cnt_o on every edge with update_i=1 and increment miss_cnt_o on every edge with mispredict_o=1.
REQ-031 SHALL, with BHT_STATS_EN defined, saturate both counters at 16'hFFFF and zero both on clear_i.
REQ-032 SHALL, without BHT_STATS_EN, keep the same ports, tie branch_cnt_o and miss_cnt_o to constant 0, and instantiate no counter flops.

Verification
REQ-033 SHALL cover reset lookup: rst_i low then high; pc_i=0x00,0x04,0x3C -> predict_o=1 for each, counters 0/0.
REQ-034 SHALL cover the saturation walk: three NT updates at update_pc_i=0x08 with predicted_i=1,1,0 -> predict_o for pc_i=0x08 goes 1,0,0; mispredict_o pulses 1,1,0; miss_cnt_o=2, branch_cnt_o=3; a fourth NT update leaves the counter at 00.
REQ-035 SHALL cover same-cycle lookup/update: pc_i=update_pc_i=0x10, counter 10, NT update -> predict_o=1 that cycle and 0 the next.
REQ-036 SHALL cover aliasing: update at 0x40 with ENTRIES=16 -> prediction for pc_i=0x00 changes identically; prediction for 0x04 is unchanged.
REQ-037 SHALL cover clear priority: clear_i=1 and an NT update on the same edge -> all entries 11, stats 0.
REQ-038 SHALL cover async reset mid-run: rst_i low between edges -> counters 0 and predict_o=1 before the next edge; with BHT_STATS_EN undefined, stats outputs stay 0 throughout all scenarios.

Source files
------------

// File: rtl/bht_predictor.sv
// -----------------------------------------------------------------------------
// bht_predictor
//
// Purpose:
//   Branch history table built from ENTRIES two-bit saturating counters.
//   The IF stage looks up a prediction for pc_i. The EX stage trains the
//   table when a branch resolves. A misprediction flag from this block drives
//   the IF/ID flush.
//
// Counter encoding:
//   00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
//   Reset and clear both put every entry in strong taken.
//
// Parameters:
//   ENTRIES       number of counters; a power of two from 4 to 256
//   IDX_W         log2(ENTRIES)
//
// Ports:
//   clk_i         clock; all state changes on its rising edge
//   rst_i         asynchronous, active-low reset
//   pc_i          IF-stage PC used for the lookup
//   predict_o     combinational prediction for pc_i (1 = taken)
//   update_i      a branch resolved in EX this cycle
//   update_pc_i   PC of the resolving branch
//   taken_i       actual outcome of the resolving branch
//   predicted_i   prediction that travelled down the pipe with that branch
//   clear_i       synchronous clear of the whole table and of the statistics
//   mispredict_o  combinational: update_i & (taken_i ^ predicted_i)
//   branch_cnt_o  count of resolved branches (saturates at 16'hFFFF)
//   miss_cnt_o    count of mispredictions (saturates at 16'hFFFF)
//
// Configuration:
//   BHT_STATS_EN  define this macro to build the two statistics counters.
//                 Without it, branch_cnt_o and miss_cnt_o are tied to zero
//                 and no counter flops are built.
// -----------------------------------------------------------------------------
module bht_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        predict_o,
  input  logic        update_i,
  input  logic [31:0] update_pc_i,
  input  logic        taken_i,
  input  logic        predicted_i,
  input  logic        clear_i,
  output logic        mispredict_o,
  output logic [15:0] branch_cnt_o,
  output logic [15:0] miss_cnt_o
);

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // Next state of one two-bit saturating counter after a resolved branch.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    case (ctr)
      CTR_STRONG_NT: nxt = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
      CTR_WEAK_NT:   nxt = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
      CTR_WEAK_T:    nxt = taken ? CTR_STRONG_T : CTR_WEAK_NT;
      CTR_STRONG_T:  nxt = taken ? CTR_STRONG_T : CTR_WEAK_T;
      default:       nxt = CTR_STRONG_T;
    endcase
    return nxt;
  endfunction

  logic [1:0]       r_table [ENTRIES];
  logic [IDX_W-1:0] w_lkp_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [1:0]       w_upd_next;
  logic             w_mispredict;
  logic             w_unused_pc_bits;

  // Word-aligned PCs: bits [1:0] are dropped. Upper bits alias into the table.
  assign w_lkp_idx = pc_i[IDX_W+1:2];
  assign w_upd_idx = update_pc_i[IDX_W+1:2];

  // The PC bits outside the index field have no effect on the table.
  assign w_unused_pc_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0],
                              update_pc_i[31:IDX_W+2], update_pc_i[1:0]};

  // The lookup reads the stored value directly, with no bypass. If lookup and
  // update hit the same entry in one cycle, the old value is seen first.
  assign predict_o = r_table[w_lkp_idx][1];

  assign w_mispredict = update_i & (taken_i ^ predicted_i);
  assign mispredict_o = w_mispredict;

  // Compute the new value of the entry being trained.
  always_comb begin
    w_upd_next = CTR_STRONG_T;
    if (update_i) begin
      w_upd_next = ctr_next(r_table[w_upd_idx], taken_i);
    end else begin
      w_upd_next = r_table[w_upd_idx];
    end
  end

  // Counter table: reset and clear set every entry to strong taken.
  // Clear has priority over an update on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CTR_STRONG_T;
      end
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CTR_STRONG_T;
      end
    end else if (update_i) begin
      r_table[w_upd_idx] <= w_upd_next;
    end
  end

`ifdef BHT_STATS_EN
  logic [15:0] r_branch_cnt;
  logic [15:0] r_miss_cnt;

  // Statistics: saturating counts of resolved branches and mispredictions.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_branch_cnt <= 16'd0;
      r_miss_cnt   <= 16'd0;
    end else if (clear_i) begin
      r_branch_cnt <= 16'd0;
      r_miss_cnt   <= 16'd0;
    end else begin
      if (update_i && (r_branch_cnt != 16'hFFFF)) begin
        r_branch_cnt <= r_branch_cnt + 16'd1;
      end
      if (w_mispredict && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  assign branch_cnt_o = r_branch_cnt;
  assign miss_cnt_o   = r_miss_cnt;
`else
  assign branch_cnt_o = 16'd0;
  assign miss_cnt_o   = 16'd0;
`endif

endmodule
